// File: rtl/prbg_seq_ctrl.sv
// Sequencing controller for the KCR pseudorandom bit generator: owns the KCR
// configuration, strobes loads, drops warm-up bits and packs Z into words.
module prbg_seq_ctrl #(
  parameter int WORD_W       = 8,
  parameter int SEED_HOLD    = 2,
  parameter int WARMUP       = 4,
  parameter int RESEED_WORDS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  input  logic              go,
  input  logic              stop,
  output logic [31:0]       gen_seed,
  output logic [11:0]       gen_mul,
  output logic [15:0]       gen_inc,
  output logic              gen_start,
  input  logic              gen_z,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_t;

  localparam logic [15:0] HOLD_LAST   = 16'(SEED_HOLD - 1);
  localparam logic [15:0] WARM_LAST   = 16'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [4:0]  BIT_LAST    = 5'(WORD_W - 1);
  localparam logic [15:0] RESEED_LAST = 16'((RESEED_WORDS > 0) ? RESEED_WORDS - 1 : 0);

  state_t state, state_d;

  logic [7:0]        x, y, p, q, b3, b4;
  logic [2:0]        r1, r2, r3, r4;
  logic [15:0]       phase_cnt;
  logic [4:0]        bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] word;
  logic [15:0]       word_cnt;
  logic [1:0]        fifo_cnt;
  logic [WORD_W-1:0] fifo_q [2];
  logic              wr_pos;
  logic              space, pop, push_req, push_ok, reseed, start_run;

  // ---------------- configuration registers ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x  <= 8'd25;
      y  <= 8'd15;
      p  <= 8'd10;
      q  <= 8'd13;
      b3 <= 8'd47;
      b4 <= 8'd23;
      r1 <= 3'd4;
      r2 <= 3'd2;
      r3 <= 3'd4;
      r4 <= 3'd3;
    end else if (cfg_we && state == IDLE) begin
      case (cfg_addr)
        3'd0: x  <= cfg_data;
        3'd1: y  <= cfg_data;
        3'd2: p  <= cfg_data;
        3'd3: q  <= cfg_data;
        3'd4: b3 <= cfg_data;
        3'd5: b4 <= cfg_data;
        3'd6: begin
          r1 <= cfg_data[5:3];
          r2 <= cfg_data[2:0];
        end
        3'd7: begin
          r3 <= cfg_data[5:3];
          r4 <= cfg_data[2:0];
        end
      endcase
    end
  end

  assign gen_seed  = {x, y, p, q};
  assign gen_mul   = {r1, r2, r3, r4};
  assign gen_inc   = {b3, b4};
  assign gen_start = (state == LOAD);
  assign busy      = (state != IDLE);

  // ---------------- handshake / buffer status ----------------
  assign word       = {shreg[WORD_W-2:0], gen_z};
  assign dout_valid = (fifo_cnt != 2'd0);
  assign dout       = fifo_q[0];
  assign pop        = dout_valid && dout_ready;
  assign space      = (fifo_cnt != 2'd2) || pop;
  assign push_ok    = push_req && space;
  assign wr_pos     = ((fifo_cnt - {1'b0, pop}) == 2'd1);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state;
    push_req  = 1'b0;
    reseed    = 1'b0;
    start_run = 1'b0;
    case (state)
      IDLE: if (go) begin
        state_d   = LOAD;
        start_run = 1'b1;
      end
      LOAD: begin
        if (stop)                         state_d = IDLE;
        else if (phase_cnt == HOLD_LAST)  state_d = (WARMUP == 0) ? RUN : WARM;
      end
      WARM: begin
        if (stop)                         state_d = IDLE;
        else if (phase_cnt == WARM_LAST)  state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (bit_cnt == BIT_LAST) begin
          push_req = 1'b1;
          // Only a word that actually lands in the buffer counts towards a reload.
          if (RESEED_WORDS != 0 && space && word_cnt == RESEED_LAST) begin
            reseed  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      word_cnt  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (state_d != state || state == IDLE) phase_cnt <= '0;
      else                                   phase_cnt <= phase_cnt + 16'd1;

      if (state == RUN && state_d == RUN && bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 5'd1;
      else                                                       bit_cnt <= '0;

      if (state == RUN) shreg <= word;

      if (start_run || reseed)                  word_cnt <= '0;
      else if (push_ok && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;

      if (start_run)                overrun <= 1'b0;
      else if (push_req && !space)  overrun <= 1'b1;
    end
  end

  // Two-entry buffer; entry 0 is always the head presented on dout.
  // NOTE: FIFO entries are reset too, so dout reads 0 out of reset rather than X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (pop)     fifo_q[0]      <= fifo_q[1];
      if (push_ok) fifo_q[wr_pos] <= word;
      fifo_cnt <= fifo_cnt + {1'b0, push_ok} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_prbg_seq_ctrl.sv
// Self-checking bench for prbg_seq_ctrl: a stand-in generator feeds gen_z and a
// timing model derived from the load/warm/run rules predicts every word.
module tb_prbg_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        go, stop, dout_ready;
  logic        go_r, stop_r, dout_ready_r;

  logic [31:0] gen_seed, gen_seed_r;
  logic [11:0] gen_mul, gen_mul_r;
  logic [15:0] gen_inc, gen_inc_r;
  logic        gen_start, gen_start_r;
  logic        gen_z, gen_z_r;
  logic [7:0]  dout, dout_r;
  logic        dout_valid, dout_valid_r;
  logic        busy, busy_r;
  logic        overrun, overrun_r;

  int total = 0;
  int bad   = 0;

  logic [31:0] salt;
  logic [31:0] g, g_r;
  logic        zh [0:127];
  logic        zr [0:127];
  logic [7:0]  m  [0:7];
  logic [7:0]  words_r [$];

  always #5 clk = ~clk;

  prbg_seq_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .go(go), .stop(stop), .gen_seed(gen_seed), .gen_mul(gen_mul), .gen_inc(gen_inc),
    .gen_start(gen_start), .gen_z(gen_z), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .overrun(overrun)
  );

  prbg_seq_ctrl #(.RESEED_WORDS(3)) dut_r (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .go(go_r), .stop(stop_r), .gen_seed(gen_seed_r), .gen_mul(gen_mul_r), .gen_inc(gen_inc_r),
    .gen_start(gen_start_r), .gen_z(gen_z_r), .dout(dout_r), .dout_valid(dout_valid_r),
    .dout_ready(dout_ready_r), .busy(busy_r), .overrun(overrun_r)
  );

  // Stand-in for KCR: deterministic stream that restarts from the config on every load.
  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)            g <= 32'h1;
    else if (gen_start) g <= (gen_seed ^ {gen_inc, gen_mul, 4'h0} ^ salt) | 32'h1;
    else                g <= xs(g);
  end

  always @(posedge clk or posedge rst) begin
    if (rst)              g_r <= 32'h1;
    else if (gen_start_r) g_r <= (gen_seed_r ^ {gen_inc_r, gen_mul_r, 4'h0} ^ salt) | 32'h1;
    else                  g_r <= xs(g_r);
  end

  assign gen_z   = g[0];
  assign gen_z_r = g_r[0];

  // Word built from the bits seen in cycles s..s+7, first bit as MSB.
  function automatic logic [7:0] pack(input bit use_r, input int s);
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < 8; i++) w = {w[6:0], use_r ? zr[s+i] : zh[s+i]};
    return w;
  endfunction

  function automatic logic [31:0] m_seed();
    return {m[0], m[1], m[2], m[3]};
  endfunction

  function automatic logic [11:0] m_mul();
    return {m[6][5:0], m[7][5:0]};
  endfunction

  function automatic logic [15:0] m_inc();
    return {m[4], m[5]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_gen_start"}, gen_start, 0);
    check({tag, "_valid"},     dout_valid, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_overrun"},   overrun, 0);
    check({tag, "_dout"},      dout, 0);
    check({tag, "_seed"},      gen_seed, 32'h190F0A0D);
    check({tag, "_mul"},       gen_mul, 12'h8A3);
    check({tag, "_inc"},       gen_inc, 16'h2F17);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    go = 1'b0; stop = 1'b0; dout_ready = 1'b1;
    go_r = 1'b0; stop_r = 1'b0; dout_ready_r = 1'b1;
    salt = $urandom;
    m[0] = 8'd25; m[1] = 8'd15; m[2] = 8'd10; m[3] = 8'd13;
    m[4] = 8'd47; m[5] = 8'd23; m[6] = 8'h22;  m[7] = 8'h23;

    // ---- reset ----
    #2 rst = 1'b1;
    #1 check_reset_state("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("idle");

    // ---- default run, consumer always ready ----
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      zh[c] = gen_z;
      check("run_busy",  busy, 1);
      check("run_start", gen_start, (c <= 2));
      check("run_valid", dout_valid, (c >= 15 && (c - 15) % 8 == 0));
      if (c >= 15 && (c - 15) % 8 == 0) check("run_word", dout, pack(0, c - 8));
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", busy, 0);

    // ---- config writes while idle ----
    cfg_write(3'd0, 8'h5A); m[0] = 8'h5A;
    cfg_write(3'd6, 8'h23); m[6] = 8'h23;
    for (int a = 1; a <= 7; a++) begin
      if (a != 6) begin
        logic [7:0] d;
        d = 8'($urandom);
        cfg_write(3'(a), d);
        m[a] = d;
      end
    end
    check("cfg_x",    gen_seed[31:24], 8'h5A);
    check("cfg_r1",   gen_mul[11:9], 3'd4);
    check("cfg_r2",   gen_mul[8:6], 3'd3);
    check("cfg_seed", gen_seed, m_seed());
    check("cfg_mul",  gen_mul, m_mul());
    check("cfg_inc",  gen_inc, m_inc());

    // ---- consumer stalled: buffer fills, overrun, busy-time writes ignored ----
    dout_ready = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      zh[c] = gen_z;
      check("stall_valid",   dout_valid, (c >= 15));
      check("stall_overrun", overrun, (c >= 31));
      case (c)
        1: begin cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'hA5; end
        2: begin cfg_addr = 3'd6; cfg_data = 8'h1C; end
        3: cfg_we = 1'b0;
        4: begin
          check("busy_seed", gen_seed, m_seed());
          check("busy_mul",  gen_mul, m_mul());
        end
        default: ;
      endcase
      @(negedge clk);
    end
    check("ovr_head",  dout, pack(0, 7));
    check("ovr_valid", dout_valid, 1);
    dout_ready = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("drain_busy",  busy, 0);
    check("drain_valid", dout_valid, 1);
    check("drain_word2", dout, pack(0, 15));
    @(negedge clk);
    check("drain_empty",  dout_valid, 0);
    check("drain_sticky", overrun, 1);

    // ---- stop mid-word, overrun cleared by next go ----
    dout_ready = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      zh[c] = gen_z;
      if (c == 1) check("go_clears_overrun", overrun, 0);
      check("mid_valid", dout_valid, (c >= 15));
      if (c == 19) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    check("mid_busy",  busy, 0);
    check("mid_valid_kept", dout_valid, 1);
    check("mid_word",  dout, pack(0, 7));
    dout_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("mid_no_partial", dout_valid, 0);
    end

    // ---- automatic reload after 3 words ----
    go_r = 1'b1;
    @(negedge clk);
    go_r = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      int  o;
      bit  v;
      o = (c - 1) % 30;
      v = (c >= 2) && (((c - 2) % 30 == 13) || ((c - 2) % 30 == 21) || ((c - 2) % 30 == 29));
      zr[c] = gen_z_r;
      check("rs_start", gen_start_r, (o < 2));
      check("rs_valid", dout_valid_r, v);
      if (v) begin
        check("rs_word", dout_r, pack(1, c - 8));
        words_r.push_back(dout_r);
      end
      @(negedge clk);
    end
    check("rs_count", words_r.size(), 5);
    if (words_r.size() >= 4) check("rs_repeat", words_r[3], words_r[0]);
    stop_r = 1'b1;
    @(negedge clk);
    stop_r = 1'b0;
    check("rs_stop_busy", busy_r, 0);

    // ---- asynchronous reset mid-run ----
    dout_ready = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (32) @(negedge clk);
    check("pre_rst_valid",   dout_valid, 1);
    check("pre_rst_overrun", overrun, 1);
    check("pre_rst_busy",    busy, 1);
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy",  busy, 0);
    check("post_rst_valid", dout_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
